dram_arbiter: RTL
=================

Name: dram_arbiter

Overview:
- Sequencer and arbiter for the single-port, word-wide data RAM, shared between the instruction-fetch port (read only) and the MEM-stage port (read/write with byte enables).
- Owns every RAM access. Performs the read-modify-write for sub-word stores (SB/SH), so the MEM stage never merges lanes itself.
- Sits between IF/MEM and the RAM. Its busy/done outputs drive the pipeline stall logic.

Parameters:
- ADDR_W, 32: byte-address width for both requesters and the RAM address.
- RAM_LAT, 1: RAM read latency in cycles. Legal range 1..7.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch read request
- if_addr_i  in  ADDR_W  fetch byte address
- if_gnt_o  out  1  one-cycle grant pulse; fetch request has been captured
- if_rvalid_o  out  1  one-cycle pulse; if_rdata_o is valid
- if_rdata_o  out  32  fetched word
- mem_req_i  in  1  MEM-stage request
- mem_we_i  in  1  1 = store, 0 = load
- mem_be_i  in  4  byte-lane enables; lane i = bits [8i+7:8i]
- mem_addr_i  in  ADDR_W  MEM byte address
- mem_wdata_i  in  32  store data, already lane-positioned
- mem_gnt_o  out  1  one-cycle grant pulse
- mem_done_o  out  1  one-cycle completion pulse (loads and stores)
- mem_rdata_o  out  32  full loaded word; MEM stage extracts and extends the lane
- ram_en_o  out  1  RAM access strobe
- ram_we_o  out  1  RAM write (full word)
- ram_addr_o  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM read data
- busy_o  out  1  1 whenever the state is not IDLE

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - state=IDLE; latency counter=0; last-grant=IF.
  - All outputs 0.
  - Any in-flight access is abandoned with no done/rvalid pulse. Requesters must re-issue.
- RAM contract:
  - Read issued in cycle t (ram_en_o=1, ram_we_o=0) returns ram_rdata_i in cycle t+RAM_LAT.
  - Write commits in its issue cycle.
- All outputs are registered. Requests are sampled only in IDLE.
- Arbitration: fixed priority, MEM over IF.
- Capture: at the sampling edge (cycle 0), the winner's addr/we/be/wdata are latched. Requester inputs are don't-care afterwards.
- States: IDLE, ISSUE, RD_WAIT, RMW_WAIT, WRITE, DONE.
- IDLE:
  - Any request → ISSUE. The winner's gnt pulses in cycle 1.
  - No request → stay in IDLE.
- ISSUE (cycle 1): ram_en_o=1, ram_addr_o=latched address.
  - Load or IF fetch: ram_we_o=0 → RD_WAIT.
  - Store with be=4'hF: ram_we_o=1, ram_wdata_o=wdata → DONE.
  - Store with be partial (nonzero, not F): ram_we_o=0 (read phase) → RMW_WAIT.
  - Store with be=0: no RAM strobe, ram_en_o=0 → DONE.
- RD_WAIT:
  - Counts RAM_LAT cycles.
  - In cycle 1+RAM_LAT, captures ram_rdata_i into the owner's rdata register → DONE.
- RMW_WAIT:
  - Counts RAM_LAT cycles.
  - In cycle 1+RAM_LAT, forms merged[lane i] = be[i] ? wdata lane i : ram_rdata_i lane i → WRITE.
- WRITE: ram_en_o=1, ram_we_o=1, ram_wdata_o=merged, same address → DONE.
- DONE: one-cycle owner pulse (if_rvalid_o or mem_done_o) → IDLE.
- Done latencies (from sample cycle 0):
  - Load/fetch: 2+RAM_LAT.
  - Full store: 2.
  - be=0 store: 2.
  - Partial store: 3+RAM_LAT.
- Back-to-back: the next request is sampled the cycle after DONE, because IDLE follows DONE.
- Request rules:
  - A requester must deassert req by its done cycle unless it wants another access.
  - A request dropped before grant has no effect.
- Data holding: rdata registers hold their value until the next capture for the same owner.
- busy_o=1 from cycle 1 through DONE inclusive.
- Address bits [1:0] never reach the RAM.

Optional Feature:
- Macro: DRAM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requesters are active in IDLE, grant goes to the requester not granted last. A single requester always wins. last-grant updates on each grant. This bounds starvation to one transaction.
- Undefined: fixed MEM-over-IF priority. last-grant logic is absent.

Test Plan:
- RAM_LAT=1, IF req addr 0x104 with RAM word 0xDEADBEEF → if_gnt_o in cycle 1; ram_addr_o=0x104; if_rvalid_o in cycle 3 with if_rdata_o=0xDEADBEEF.
- MEM SW addr 0x20, be=F, wdata 0x12345678 → single write strobe in cycle 1; mem_done_o in cycle 2; RAM[0x20]=0x12345678.
- RAM[0x20]=0xAABBCCDD; SB addr 0x22, be=4'b0100, wdata 0x00EE0000 → read strobe in cycle 1, write strobe in cycle 3; RAM=0xAAEECCDD; mem_done_o in cycle 4. With RAM_LAT=3: write strobe in cycle 5, done in cycle 6.
- IF and MEM request in the same cycle, held for two transactions →
  - Macro undefined: MEM granted first, then MEM again (IF starves while mem_req_i stays high).
  - DRAM_ARB_RR_EN defined: MEM, then IF.
- rst_ni pulled low in RMW_WAIT → all outputs 0 immediately; no write strobe, no mem_done_o; next request after release starts a fresh transaction from ISSUE.
- MEM store with be=0 → no ram_en_o pulse; mem_done_o in cycle 2.

Source files
------------

// File: rtl/dram_arbiter_if.sv
// -----------------------------------------------------------------------------
// dram_arbiter_if
// Bundle of every signal between the data-RAM arbiter and its neighbours:
// the instruction-fetch requester, the MEM-stage requester and the RAM itself.
//
// Signals (direction as seen by the arbiter, modport "slave"):
//   if_req_i / if_addr_i                fetch request and byte address
//   if_gnt_o / if_rvalid_o / if_rdata_o fetch grant, data-valid, fetched word
//   mem_req_i / mem_we_i / mem_be_i     MEM request, store flag, byte lanes
//   mem_addr_i / mem_wdata_i            MEM byte address, lane-positioned data
//   mem_gnt_o / mem_done_o / mem_rdata_o MEM grant, completion, loaded word
//   ram_en_o / ram_we_o / ram_addr_o    RAM strobe, write flag, word address
//   ram_wdata_o / ram_rdata_i           RAM write and read data
//   busy_o                              arbiter is in a transaction
// Modport "master" is the mirror image, used by the requesters/RAM (or a bench).
// -----------------------------------------------------------------------------
interface dram_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_gnt_o;
   logic              if_rvalid_o;
   logic [31:0]       if_rdata_o;

   logic              mem_req_i;
   logic              mem_we_i;
   logic [3:0]        mem_be_i;
   logic [ADDR_W-1:0] mem_addr_i;
   logic [31:0]       mem_wdata_i;
   logic              mem_gnt_o;
   logic              mem_done_o;
   logic [31:0]       mem_rdata_o;

   logic              ram_en_o;
   logic              ram_we_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic [31:0]       ram_wdata_o;
   logic [31:0]       ram_rdata_i;

   logic              busy_o;

   modport slave (
      input  if_req_i, if_addr_i,
      input  mem_req_i, mem_we_i, mem_be_i, mem_addr_i, mem_wdata_i,
      input  ram_rdata_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o,
      output mem_gnt_o, mem_done_o, mem_rdata_o,
      output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
      output busy_o
   );

   modport master (
      output if_req_i, if_addr_i,
      output mem_req_i, mem_we_i, mem_be_i, mem_addr_i, mem_wdata_i,
      output ram_rdata_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o,
      input  mem_gnt_o, mem_done_o, mem_rdata_o,
      input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
      input  busy_o
   );
endinterface

// File: rtl/dram_arbiter.sv
// -----------------------------------------------------------------------------
// dram_arbiter
// Sequencer/arbiter for the single-port word-wide data RAM shared by the
// instruction fetch (read only) and the MEM stage (loads, stores with byte
// enables). Sub-word stores are done here as read-modify-write so the MEM
// stage never merges lanes. busy_o and the done pulses feed the stall logic.
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset; abandons any access in flight
//   bus     dram_arbiter_if.slave - fetch port, MEM port, RAM port, busy_o
//
// Parameters:
//   ADDR_W   byte-address width (>= 3)
//   RAM_LAT  RAM read latency in cycles, 1..7
//
// Build option:
//   DRAM_ARB_RR_EN  defined  -> round-robin between fetch and MEM
//                   undefined -> fixed priority, MEM over fetch
//
// Every output comes straight from a flop; requests are looked at only in
// IDLE and the winner's fields are latched at that edge.
// -----------------------------------------------------------------------------
module dram_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int RAM_LAT = 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   dram_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_RD_WAIT,
      S_RMW_WAIT,
      S_WRITE,
      S_DONE
   } state_e;

   typedef enum logic {
      OWN_IF,
      OWN_MEM
   } owner_e;

   localparam logic [2:0] LAT_C = 3'(RAM_LAT);

   state_e            state_q;
   owner_e            owner_q;
   logic [2:0]        cnt_q;
   logic              we_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;

   logic              if_gnt_q, if_rvalid_q, mem_gnt_q, mem_done_q;
   logic [31:0]       if_rdata_q, mem_rdata_q;
   logic              ram_en_q, ram_we_q, busy_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [31:0]       ram_wdata_q;

`ifdef DRAM_ARB_RR_EN
   owner_e            last_q;
`endif

   // ---------------------------------------------------------------- arbitration
   logic              req_any;
   owner_e            winner;
   logic              win_we;
   logic [3:0]        win_be;
   logic [31:0]       win_wdata;
   logic [ADDR_W-1:0] win_addr;

   // NOTE: every output of this block is assigned a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      req_any   = bus.if_req_i | bus.mem_req_i;
      winner    = bus.mem_req_i ? OWN_MEM : OWN_IF;
`ifdef DRAM_ARB_RR_EN
      // Contention goes to whoever was not granted last.
      if (bus.if_req_i && bus.mem_req_i)
         winner = (last_q == OWN_MEM) ? OWN_IF : OWN_MEM;
`endif
      // A fetch is a plain read, so only the MEM side contributes we/be/wdata.
      win_we    = 1'b0;
      win_be    = 4'h0;
      win_wdata = 32'h0;
      win_addr  = bus.if_addr_i;
      if (winner == OWN_MEM) begin
         win_we    = bus.mem_we_i;
         win_be    = bus.mem_be_i;
         win_wdata = bus.mem_wdata_i;
         win_addr  = bus.mem_addr_i;
      end
   end

   // Lane merge for sub-word stores: new lanes from the store, the rest from
   // the word just read back.
   logic [31:0] merged;
   always_comb begin
      merged = 32'h0;
      for (int i = 0; i < 4; i++)
         merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : bus.ram_rdata_i[8*i +: 8];
   end

   // ---------------------------------------------------------------- sequencer
   // NOTE: all state and output flops use non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_IF;
         cnt_q       <= 3'd0;
         we_q        <= 1'b0;
         be_q        <= 4'h0;
         wdata_q     <= 32'h0;
         if_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= 32'h0;
         mem_gnt_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         mem_rdata_q <= 32'h0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= 32'h0;
         busy_q      <= 1'b0;
`ifdef DRAM_ARB_RR_EN
         last_q      <= OWN_IF;
`endif
      end else begin
         // Pulses and strobes last exactly one cycle unless re-armed below.
         if_gnt_q    <= 1'b0;
         mem_gnt_q   <= 1'b0;
         if_rvalid_q <= 1'b0;
         mem_done_q  <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (req_any) begin
                  state_q     <= S_ISSUE;
                  busy_q      <= 1'b1;
                  owner_q     <= winner;
                  we_q        <= win_we;
                  be_q        <= win_be;
                  wdata_q     <= win_wdata;
                  // Byte offset is dropped; the RAM only ever sees word addresses.
                  ram_addr_q  <= win_addr & ~ADDR_W'(3);
                  // Issue-cycle outputs are set up now so they appear in ISSUE.
                  ram_en_q    <= !(win_we && (win_be == 4'h0));
                  ram_we_q    <= win_we && (win_be == 4'hF);
                  ram_wdata_q <= (win_we && (win_be == 4'hF)) ? win_wdata : 32'h0;
                  if (winner == OWN_MEM) mem_gnt_q <= 1'b1;
                  else                   if_gnt_q  <= 1'b1;
`ifdef DRAM_ARB_RR_EN
                  last_q      <= winner;
`endif
               end
            end

            S_ISSUE: begin
               if (!we_q) begin
                  state_q <= S_RD_WAIT;
                  cnt_q   <= 3'd1;
               end else if ((be_q == 4'hF) || (be_q == 4'h0)) begin
                  // Full store already committed; empty store never touched the RAM.
                  state_q    <= S_DONE;
                  mem_done_q <= 1'b1;
               end else begin
                  state_q <= S_RMW_WAIT;
                  cnt_q   <= 3'd1;
               end
            end

            S_RD_WAIT: begin
               if (cnt_q == LAT_C) begin
                  cnt_q   <= 3'd0;
                  state_q <= S_DONE;
                  if (owner_q == OWN_MEM) begin
                     mem_rdata_q <= bus.ram_rdata_i;
                     mem_done_q  <= 1'b1;
                  end else begin
                     if_rdata_q  <= bus.ram_rdata_i;
                     if_rvalid_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end

            S_RMW_WAIT: begin
               if (cnt_q == LAT_C) begin
                  cnt_q       <= 3'd0;
                  state_q     <= S_WRITE;
                  ram_en_q    <= 1'b1;
                  ram_we_q    <= 1'b1;
                  ram_wdata_q <= merged;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end

            S_WRITE: begin
               state_q    <= S_DONE;
               mem_done_q <= 1'b1;
            end

            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.if_gnt_o    = if_gnt_q;
   assign bus.if_rvalid_o = if_rvalid_q;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.mem_gnt_o   = mem_gnt_q;
   assign bus.mem_done_o  = mem_done_q;
   assign bus.mem_rdata_o = mem_rdata_q;
   assign bus.ram_en_o    = ram_en_q;
   assign bus.ram_we_o    = ram_we_q;
   assign bus.ram_addr_o  = ram_addr_q;
   assign bus.ram_wdata_o = ram_wdata_q;
   assign bus.busy_o      = busy_q;

endmodule
